// File: rtl/gelato_wb_arbiter.sv
// Round-robin arbiter sharing the SM register-writeback port among execution units.
// Grants one completed warp result per cycle into a single registered writeback beat.
module gelato_wb_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int WARP_ID_W = 5,
  parameter int REG_ID_W  = 5,
  parameter int THREADS   = 32,
  parameter int DATA_W    = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rdy,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [NUM_SRC*WARP_ID_W-1:0]        src_warp,
  input  logic [NUM_SRC*REG_ID_W-1:0]         src_rd,
  input  logic [NUM_SRC*THREADS-1:0]          src_mask,
  input  logic [NUM_SRC*THREADS*DATA_W-1:0]   src_data,
  output logic                                wb_valid,
  input  logic                                wb_ready,
  output logic [WARP_ID_W-1:0]                wb_warp,
  output logic [REG_ID_W-1:0]                 wb_rd,
  output logic [THREADS-1:0]                  wb_mask,
  output logic [THREADS*DATA_W-1:0]           wb_data
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LANE_W = THREADS * DATA_W;

  // Handshakes: a source transfer is src_valid[i] & src_ready[i]; a source holds valid
  // and payload stable until granted. A writeback beat moves on wb_valid & wb_ready & rdy.
  // Reset is active-high despite the port name (rst_n = 1 resets).

  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 found;
  logic                 can_load;
  int                   idx;
  logic [WARP_ID_W-1:0] sel_warp;
  logic [REG_ID_W-1:0]  sel_rd;
  logic [THREADS-1:0]   sel_mask;
  logic [LANE_W-1:0]    sel_data;

  // Grant depends only on valid bits and output-register state, never on payload.
  always_comb begin
    can_load  = rdy & ~rst_n & (~wb_valid | wb_ready);
    found     = 1'b0;
    grant_idx = last_grant;
    idx       = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (!found && src_valid[IDX_W'(idx)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
    src_ready = '0;
    if (can_load && found) src_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_warp = '0;
    sel_rd   = '0;
    sel_mask = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_warp = src_warp[i*WARP_ID_W +: WARP_ID_W];
        sel_rd   = src_rd[i*REG_ID_W +: REG_ID_W];
        sel_mask = src_mask[i*THREADS +: THREADS];
        sel_data = src_data[i*LANE_W +: LANE_W];
      end
    end
  end

  // rd==0 and empty masks are forwarded untouched: the scoreboard still needs the release.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wb_valid   <= 1'b0;
      wb_warp    <= '0;
      wb_rd      <= '0;
      wb_mask    <= '0;
      wb_data    <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
    end else if (can_load) begin
      if (found) begin
        wb_valid   <= 1'b1;
        wb_warp    <= sel_warp;
        wb_rd      <= sel_rd;
        wb_mask    <= sel_mask;
        wb_data    <= sel_data;
        last_grant <= grant_idx;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule
